// File: rtl/pla_sweep_profiler.sv
// Drives every PLA input vector (binary or Gray order) and counts per-output toggles.
// Latency: 2 cycles per vector (drive, then settle/sample); 2^NIN*2 + 1 cycles start to done.
// Backpressure: none; start is honoured only when idle, and abort cancels a sweep within one edge.
module pla_sweep_profiler #(
    parameter int NIN   = 5,
    parameter int NOUT  = 14,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    output logic [NIN-1:0]     pla_in,
    input  logic [NOUT-1:0]    pla_out,
    output logic               busy,
    output logic               done,
    input  logic [3:0]         rd_idx,
    output logic [CNT_W-1:0]   rd_cnt,
    output logic [CNT_W+3:0]   total_toggles
);

    localparam int TW  = CNT_W + 4;
    localparam int TW1 = TW + 1;
    localparam int PW  = $clog2(NOUT + 1);
    localparam logic [NIN-1:0]   LAST_VEC = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NIN-1:0]   vec;
    logic [NIN-1:0]   vec_nxt;
    logic [NOUT-1:0]  prev;
    logic [NOUT-1:0]  diff;
    logic             mode_q;
    logic [CNT_W-1:0] cnt [NOUT];
    logic [PW-1:0]    pop;
    logic [TW:0]      total_sum;
    logic [TW-1:0]    total_sat;
    logic             accept;
    logic             sample_upd;

    function automatic logic [NIN-1:0] seq_of(input logic [NIN-1:0] i, input logic gray);
        return gray ? (i ^ (i >> 1)) : i;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks every other transition, including a start seen in IDLE
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        sample_upd = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_DRIVE;
                    accept    = 1'b1;
                end
            end
            S_DRIVE: begin
                state_nxt = abort ? S_IDLE : S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    sample_upd = 1'b1;
                    state_nxt  = (vec == LAST_VEC) ? S_DONE : S_DRIVE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done    = (state == S_DONE);
    assign diff    = pla_out ^ prev;
    assign vec_nxt = vec + NIN'(1);

    always_comb begin
        pop = '0;
        for (int k = 0; k < NOUT; k++) begin
            pop = pop + PW'(diff[k]);
        end
    end

    assign total_sum = {1'b0, total_toggles} + TW1'(pop);
    assign total_sat = total_sum[TW] ? '1 : total_sum[TW-1:0];

    // vector 0 only seeds prev; toggles are counted from vector 1 onward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec           <= '0;
            pla_in        <= '0;
            prev          <= '0;
            mode_q        <= 1'b0;
            total_toggles <= '0;
            for (int k = 0; k < NOUT; k++) begin
                cnt[k] <= '0;
            end
        end else if (accept) begin
            vec           <= '0;
            pla_in        <= seq_of('0, mode);
            mode_q        <= mode;
            total_toggles <= '0;
            for (int k = 0; k < NOUT; k++) begin
                cnt[k] <= '0;
            end
        end else if (sample_upd) begin
            prev <= pla_out;
            if (vec != '0) begin
                total_toggles <= total_sat;
                for (int k = 0; k < NOUT; k++) begin
                    if (diff[k] && (cnt[k] != CNT_MAX)) begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end
            end
            if (vec != LAST_VEC) begin
                vec    <= vec_nxt;
                pla_in <= seq_of(vec_nxt, mode_q);
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        if (int'(rd_idx) < NOUT) begin
            rd_cnt = cnt[rd_idx];
        end
    end

endmodule

// File: tb/tb_pla_sweep_profiler.sv
// Scoreboard bench: a behavioural toggle model queues expected counters per sweep,
// which are popped and compared against two profilers (CNT_W=8 and CNT_W=4) when each sweep ends.
module tb_pla_sweep_profiler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic        abort;
    logic [3:0]  rd_idx;
    logic        use_ref;

    logic [4:0]  pla_in_a;
    logic [13:0] pla_out_a;
    logic        busy_a;
    logic        done_a;
    logic [7:0]  rd_cnt_a;
    logic [11:0] total_a;

    logic [4:0]  pla_in_b;
    logic [13:0] pla_out_b;
    logic        busy_b;
    logic        done_b;
    logic [3:0]  rd_cnt_b;
    logic [7:0]  total_b;

    int n_chk;
    int n_pass;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    // stand-in two-level PLA used where the real benchmark netlist would sit
    function automatic logic [13:0] pla_ref_f(input logic [4:0] v);
        logic [13:0] o;
        o[0]  = v[0] & v[1];
        o[1]  = v[2] | v[3];
        o[2]  = ^v;
        o[3]  = v[4] & ~v[0];
        o[4]  = v[1] ^ v[3];
        o[5]  = &v;
        o[6]  = ~|v;
        o[7]  = v[0] | (v[2] & v[4]);
        o[8]  = (v > 5'd12);
        o[9]  = (v[3:0] == 4'h5);
        o[10] = v[2];
        o[11] = ~v[1] & v[3];
        o[12] = (v[1:0] == v[3:2]);
        o[13] = ((v % 5'd3) == 5'd0);
        return o;
    endfunction

    assign pla_out_a = use_ref ? pla_ref_f(pla_in_a) : {9'b0, pla_in_a};
    assign pla_out_b = {9'b0, pla_in_b};

    pla_sweep_profiler u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .abort         (abort),
        .pla_in        (pla_in_a),
        .pla_out       (pla_out_a),
        .busy          (busy_a),
        .done          (done_a),
        .rd_idx        (rd_idx),
        .rd_cnt        (rd_cnt_a),
        .total_toggles (total_a)
    );

    pla_sweep_profiler #(.CNT_W(4)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .abort         (abort),
        .pla_in        (pla_in_b),
        .pla_out       (pla_out_b),
        .busy          (busy_b),
        .done          (done_b),
        .rd_idx        (rd_idx),
        .rd_cnt        (rd_cnt_b),
        .total_toggles (total_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // model: toggles over vectors 0..last of the chosen order, with saturation
    task automatic push_exp(input bit ref_pla, input bit gray, input int last);
        int ca[14];
        int cb[14];
        int ta;
        int tb;
        logic [4:0]  s;
        logic [13:0] oa, ob, pa, pb;
        ta = 0;
        tb = 0;
        pa = '0;
        pb = '0;
        for (int k = 0; k < 14; k++) begin
            ca[k] = 0;
            cb[k] = 0;
        end
        for (int v = 0; v <= last; v++) begin
            s  = gray ? 5'(v ^ (v >> 1)) : 5'(v);
            oa = ref_pla ? pla_ref_f(s) : {9'b0, s};
            ob = {9'b0, s};
            if (v > 0) begin
                for (int k = 0; k < 14; k++) begin
                    if (oa[k] != pa[k]) begin
                        if (ca[k] < 255)  ca[k]++;
                        if (ta < 4095)    ta++;
                    end
                    if (ob[k] != pb[k]) begin
                        if (cb[k] < 15)   cb[k]++;
                        if (tb < 255)     tb++;
                    end
                end
            end
            pa = oa;
            pb = ob;
        end
        for (int k = 0; k < 14; k++) begin
            qa.push_back(32'(ca[k]));
            qb.push_back(32'(cb[k]));
        end
        qa.push_back(32'(ta));
        qb.push_back(32'(tb));
    endtask

    task automatic readback(input string tag);
        logic [31:0] ea;
        logic [31:0] eb;
        if (qa.size() < 15 || qb.size() < 15) begin
            chk({tag, "_queue"}, 32'(qa.size()), 32'd15);
        end else begin
            for (int k = 0; k < 14; k++) begin
                rd_idx = 4'(k);
                @(negedge clk);
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk($sformatf("%s_a_cnt%0d", tag, k), 32'(rd_cnt_a), ea);
                chk($sformatf("%s_b_cnt%0d", tag, k), 32'(rd_cnt_b), eb);
            end
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk({tag, "_a_total"}, 32'(total_a), ea);
            chk({tag, "_b_total"}, 32'(total_b), eb);
        end
    endtask

    task automatic run_sweep(input string tag, input bit ref_pla, input bit gray, input int poke_at);
        int n;
        int busy_gap;
        use_ref = ref_pla;
        mode    = gray;
        push_exp(ref_pla, gray, 31);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~gray;
        chk({tag, "_busy_start"}, 32'(busy_a), 32'd1);
        n = 0;
        busy_gap = 0;
        while (n < 200 && !done_a) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == poke_at);
            if (!done_a && !busy_a) busy_gap++;
        end
        start = 1'b0;
        chk({tag, "_done_edge"}, 32'(n), 32'd64);
        chk({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy_a), 32'd0);
        chk({tag, "_done_b"}, 32'(done_b), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_width"}, 32'(done_a), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
        readback(tag);
    endtask

    // tgt edges after the start edge: 2v lands in DRIVE of v, 2v+1 in SAMPLE of v
    task automatic run_abort(input string tag, input int tgt, input int last_counted, input int exp_pla);
        bit saw_done;
        use_ref = 1'b0;
        mode    = 1'b0;
        push_exp(1'b0, 1'b0, last_counted);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= tgt; n++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk({tag, "_busy"}, 32'(busy_a), 32'd0);
        chk({tag, "_pla_hold"}, 32'(pla_in_a), 32'(exp_pla));
        saw_done = done_a;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done_a) saw_done = 1'b1;
        end
        chk({tag, "_no_done"}, 32'(saw_done), 32'd0);
        // start together with abort in IDLE must neither launch nor clear
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk({tag, "_start_abort_idle"}, 32'(busy_a), 32'd0);
        readback(tag);
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        abort   = 1'b0;
        rd_idx  = 4'd0;
        use_ref = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pla_in", 32'(pla_in_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_total", 32'(total_a), 32'd0);
        chk("rst_cnt0", 32'(rd_cnt_a), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_sweep("bin", 1'b0, 1'b0, 0);
        rd_idx = 4'd14;
        @(negedge clk);
        chk("rd_oob14", 32'(rd_cnt_a), 32'd0);
        rd_idx = 4'd15;
        @(negedge clk);
        chk("rd_oob15", 32'(rd_cnt_a), 32'd0);

        run_sweep("gray", 1'b0, 1'b1, 0);
        run_abort("abort_s3", 7, 2, 3);
        run_abort("abort_d4", 8, 3, 4);

        mode  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rd_idx = 4'd0;
        rst = 1'b1;
        #1;
        chk("midrst_pla_in", 32'(pla_in_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        chk("midrst_total", 32'(total_a), 32'd0);
        chk("midrst_cnt0", 32'(rd_cnt_a), 32'd0);
        chk("midrst_total_b", 32'(total_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_sweep("after_rst", 1'b0, 1'b0, 0);

        run_sweep("ref_bin", 1'b1, 1'b0, 30);
        run_sweep("ref_gray", 1'b1, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
